// File: rtl/div_arb_f32.sv
// Round-robin sequencer that shares one multi-cycle f32 divider among NREQ requesters.
// Each grant restarts the divider, waits for rdy or a timeout, then returns a tagged quotient.
module div_arb_f32 #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_num,
    input  logic [NREQ*32-1:0]   req_den,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_quo,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 div_rst,
    output logic [31:0]          div_num,
    output logic [31:0]          div_den,
    input  logic                 div_rdy,
    input  logic [31:0]          div_quo
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     num_q, num_d;
    logic [31:0]     den_q, den_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_quo_q, rsp_quo_d;
    logic            rsp_err_q, rsp_err_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [31:0]     sel_num;
    logic [31:0]     sel_den;

    // Rotating priority: first scan ptr..NREQ-1, then wrap to 0..ptr-1.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        sel_num = '0;
        sel_den = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IDW'(i) >= ptr_q)) begin
                found   = 1'b1;
                win     = IDW'(i);
                sel_num = req_num[32*i +: 32];
                sel_den = req_den[32*i +: 32];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                win     = IDW'(i);
                sel_num = req_num[32*i +: 32];
                sel_den = req_den[32*i +: 32];
            end
        end
    end

    // Handshake: a transfer happens on the rising edge where req_valid[i] && req_ready[i];
    // ready is offered only in IDLE, to one valid requester, and never waits on anything else.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        num_d       = num_q;
        den_d       = den_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_quo_d   = rsp_quo_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    id_d    = win;
                    num_d   = sel_num;
                    den_d   = sel_den;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // rdy in the first WAIT cycle may be stale from the previous operation.
                if (cnt_q != '0 && div_rdy) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = div_quo;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = QNAN;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            num_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            num_q       <= num_d;
            den_q       <= den_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_quo   = rsp_quo_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);
    assign div_rst   = rst | (state_q == S_START);
    assign div_num   = num_q;
    assign div_den   = den_q;

endmodule
